// File: rtl/ahbl_defs.sv
// ---------------------------------------------------------------------------
// ahbl_defs
// Shared AHB-Lite encodings for the memory-contract monitor:
//   - htrans_e     : HTRANS transfer types
//   - HSIZE_*      : HSIZE transfer-size codes
//   - HPROT_*      : bit positions of the bufferable / cacheable attributes
//   - is_cacheable : true when a transfer is both cacheable and bufferable
// ---------------------------------------------------------------------------
package ahbl_defs;

    typedef enum logic [1:0] {
        HTRANS_IDLE = 2'b00,
        HTRANS_BUSY = 2'b01,
        HTRANS_NSEQ = 2'b10,
        HTRANS_SEQ  = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;
    localparam logic [2:0] HSIZE_4WORD = 3'd4;
    localparam logic [2:0] HSIZE_8WORD = 3'd5;

    localparam int HPROT_BUFFERABLE = 2;
    localparam int HPROT_CACHEABLE  = 3;

    function automatic logic is_cacheable(input logic [3:0] prot);
        return prot[HPROT_CACHEABLE] & prot[HPROT_BUFFERABLE];
    endfunction

endpackage

// File: rtl/ahbl_mem_contract_chan.sv
// ---------------------------------------------------------------------------
// ahbl_mem_contract_chan
// Tracks one watched byte address: remembers the last successfully written
// byte and compares it against every qualified, successful read of it.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_done          : a data phase completes this cycle
//   i_write         : completing transfer is a write
//   i_addr, i_size  : address / size of the completing transfer
//   i_qual          : completing transfer passes the cacheability filter
//   i_hresp         : bus error response for the completing transfer
//   i_hwdata/hrdata : bus data
//   i_chan_addr     : watched byte address
//   i_clr           : clear valid and mismatch (wins over a write update)
//   o_valid         : channel holds a known byte
//   o_data          : last written byte
//   o_mismatch      : sticky read-compare failure
//   o_checks        : saturating count of compared reads
// ---------------------------------------------------------------------------
module ahbl_mem_contract_chan #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32,
    parameter int W_CNT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_done,
    input  logic              i_write,
    input  logic [W_ADDR-1:0] i_addr,
    input  logic [2:0]        i_size,
    input  logic              i_qual,
    input  logic              i_hresp,
    input  logic [W_DATA-1:0] i_hwdata,
    input  logic [W_DATA-1:0] i_hrdata,
    input  logic [W_ADDR-1:0] i_chan_addr,
    input  logic              i_clr,
    output logic              o_valid,
    output logic [7:0]        o_data,
    output logic              o_mismatch,
    output logic [W_CNT-1:0]  o_checks
);

    localparam int LANE_W = $clog2(W_DATA / 8);
    localparam logic [W_ADDR:0] ONE = 1;

    function automatic logic [W_CNT-1:0] sat_inc(input logic [W_CNT-1:0] c);
        return (&c) ? c : c + {{(W_CNT-1){1'b0}}, 1'b1};
    endfunction

    logic              r_valid;
    logic [7:0]        r_data;
    logic              r_mismatch;
    logic [W_CNT-1:0]  r_checks;

    logic [LANE_W-1:0] w_lane;
    logic [7:0]        w_wbyte;
    logic [7:0]        w_rbyte;
    logic [W_ADDR:0]   w_lo;
    logic [W_ADDR:0]   w_hi;
    logic [W_ADDR:0]   w_pt;
    logic              w_overlap;
    logic              w_wr;
    logic              w_rd;

    assign w_lane  = i_chan_addr[LANE_W-1:0];
    assign w_wbyte = 8'(i_hwdata >> {w_lane, 3'b000});
    assign w_rbyte = 8'(i_hrdata >> {w_lane, 3'b000});

    // One extra bit so a transfer at the top of the address space cannot wrap.
    assign w_lo      = {1'b0, i_addr};
    assign w_hi      = w_lo + (ONE << i_size);
    assign w_pt      = {1'b0, i_chan_addr};
    assign w_overlap = (w_pt >= w_lo) && (w_pt < w_hi);

    assign w_wr = i_done && w_overlap && i_write;
    // Only successful, qualified reads of a known byte are compared.
    assign w_rd = i_done && w_overlap && !i_write && i_qual && !i_hresp && r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_data     <= 8'h00;
            r_mismatch <= 1'b0;
            r_checks   <= '0;
        end else begin
            if (i_clr) begin
                r_valid    <= 1'b0;
                r_mismatch <= 1'b0;
            end else if (w_wr) begin
                // An error or unqualified write leaves the target byte unknown.
                if (i_qual && !i_hresp) begin
                    r_valid <= 1'b1;
                    r_data  <= w_wbyte;
                end else begin
                    r_valid <= 1'b0;
                end
            end else if (w_rd && (w_rbyte != r_data)) begin
                r_mismatch <= 1'b1;
            end
            if (w_rd) begin
                r_checks <= sat_inc(r_checks);
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_mismatch = r_mismatch;
    assign o_checks   = r_checks;

endmodule

// File: rtl/ahbl_mem_contract_monitor.sv
// ---------------------------------------------------------------------------
// ahbl_mem_contract_monitor
// Passive AHB-Lite monitor: "a byte read returns the last successfully
// written value" on N_CHAN watched addresses, plus response-protocol checks.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   ahbl_*            : observed AHB-Lite signals
//   chan_addr         : watched byte address per channel (held while valid)
//   chan_clr          : per-channel clear of valid and mismatch
//   chan_valid        : channel holds a known byte
//   chan_data         : last written byte per channel
//   chan_mismatch     : sticky read-compare failure per channel
//   chan_checks       : saturating compared-read count per channel
//   proto_err         : sticky response-protocol violation
//   err_any           : OR of all mismatch flags and proto_err
// ---------------------------------------------------------------------------
module ahbl_mem_contract_monitor
    import ahbl_defs::*;
#(
    parameter int W_ADDR        = 32,
    parameter int W_DATA        = 32,
    parameter int N_CHAN        = 4,
    parameter int W_CNT         = 16,
    parameter int REQ_CACHEABLE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ahbl_hready,
    input  logic                    ahbl_hresp,
    input  logic [1:0]              ahbl_htrans,
    input  logic                    ahbl_hwrite,
    input  logic [W_ADDR-1:0]       ahbl_haddr,
    input  logic [2:0]              ahbl_hsize,
    input  logic [3:0]              ahbl_hprot,
    input  logic [W_DATA-1:0]       ahbl_hwdata,
    input  logic [W_DATA-1:0]       ahbl_hrdata,
    input  logic [N_CHAN*W_ADDR-1:0] chan_addr,
    input  logic [N_CHAN-1:0]       chan_clr,
    output logic [N_CHAN-1:0]       chan_valid,
    output logic [N_CHAN*8-1:0]     chan_data,
    output logic [N_CHAN-1:0]       chan_mismatch,
    output logic [N_CHAN*W_CNT-1:0] chan_checks,
    output logic                    proto_err,
    output logic                    err_any
);

    // Data-phase descriptor, loaded from the address phase on each hready edge.
    logic              r_active;
    logic              r_write;
    logic [W_ADDR-1:0] r_addr;
    logic [2:0]        r_size;
    logic [3:0]        r_prot;
    // r_seen masks the previous-cycle checks on the first cycle after reset.
    logic              r_seen;
    // Previous cycle was the wait half of a two-cycle error response.
    logic              r_wait;
    logic              r_proto_err;

    logic w_done;
    logic w_qual;
    logic w_viol_idle;
    logic w_viol_noprep;
    logic w_viol_nofinish;
    logic w_viol_longwait;
    logic w_viol;
    logic w_unused_ok;

    assign w_unused_ok = ahbl_htrans[0];

    assign w_done = r_active && ahbl_hready;
    assign w_qual = (REQ_CACHEABLE == 0) || is_cacheable(r_prot);

    // Without a transfer in flight the slave must be ready with OKAY.
    assign w_viol_idle     = !r_active && (!ahbl_hready || ahbl_hresp);
    assign w_viol_noprep   = ahbl_hresp && ahbl_hready && !r_wait;
    assign w_viol_nofinish = r_wait && !ahbl_hresp;
    assign w_viol_longwait = r_wait && ahbl_hresp && !ahbl_hready;
    assign w_viol = w_viol_idle ||
                    (r_seen && (w_viol_noprep || w_viol_nofinish || w_viol_longwait));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active    <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_size      <= 3'd0;
            r_prot      <= 4'd0;
            r_seen      <= 1'b0;
            r_wait      <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            if (ahbl_hready) begin
                r_active <= ahbl_htrans[1];
                r_write  <= ahbl_hwrite;
                r_addr   <= ahbl_haddr;
                r_size   <= ahbl_hsize;
                r_prot   <= ahbl_hprot;
            end
            r_seen <= 1'b1;
            r_wait <= ahbl_hresp && !ahbl_hready;
            if (w_viol) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CHAN; gi++) begin : g_chan
            ahbl_mem_contract_chan #(
                .W_ADDR (W_ADDR),
                .W_DATA (W_DATA),
                .W_CNT  (W_CNT)
            ) u_chan (
                .clk         (clk),
                .rst         (rst),
                .i_done      (w_done),
                .i_write     (r_write),
                .i_addr      (r_addr),
                .i_size      (r_size),
                .i_qual      (w_qual),
                .i_hresp     (ahbl_hresp),
                .i_hwdata    (ahbl_hwdata),
                .i_hrdata    (ahbl_hrdata),
                .i_chan_addr (chan_addr[gi*W_ADDR +: W_ADDR]),
                .i_clr       (chan_clr[gi]),
                .o_valid     (chan_valid[gi]),
                .o_data      (chan_data[gi*8 +: 8]),
                .o_mismatch  (chan_mismatch[gi]),
                .o_checks    (chan_checks[gi*W_CNT +: W_CNT])
            );
        end
    endgenerate

    assign proto_err = r_proto_err;
    assign err_any   = (|chan_mismatch) || r_proto_err;

endmodule

// File: tb/tb_ahbl_mem_contract_monitor.sv
// ---------------------------------------------------------------------------
// tb_ahbl_mem_contract_monitor
// Drives one shared AHB-Lite bus into a 32-bit instance (2-bit counters) and
// a 64-bit instance (16-bit counters). Expected results are queued as each
// transfer is driven and compared once the transfer has completed.
// ---------------------------------------------------------------------------
module tb_ahbl_mem_contract_monitor;
    import ahbl_defs::*;

    logic        clk;
    logic        rst;
    logic        hready;
    logic        hresp;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [63:0] hwdata;
    logic [63:0] hrdata;

    logic [127:0] ca32;
    logic [127:0] ca64;
    logic [3:0]   clr32;
    logic [3:0]   clr64;

    logic [3:0]  v32,  mm32;
    logic [31:0] d32;
    logic [7:0]  ck32;
    logic        pe32, ea32;
    logic [3:0]  v64,  mm64;
    logic [31:0] d64;
    logic [63:0] ck64;
    logic        pe64, ea64;

    ahbl_mem_contract_monitor #(
        .W_ADDR(32), .W_DATA(32), .N_CHAN(4), .W_CNT(2), .REQ_CACHEABLE(1)
    ) dut32 (
        .clk(clk), .rst(rst),
        .ahbl_hready(hready), .ahbl_hresp(hresp), .ahbl_htrans(htrans),
        .ahbl_hwrite(hwrite), .ahbl_haddr(haddr), .ahbl_hsize(hsize),
        .ahbl_hprot(hprot), .ahbl_hwdata(hwdata[31:0]), .ahbl_hrdata(hrdata[31:0]),
        .chan_addr(ca32), .chan_clr(clr32),
        .chan_valid(v32), .chan_data(d32), .chan_mismatch(mm32),
        .chan_checks(ck32), .proto_err(pe32), .err_any(ea32)
    );

    ahbl_mem_contract_monitor #(
        .W_ADDR(32), .W_DATA(64), .N_CHAN(4), .W_CNT(16), .REQ_CACHEABLE(1)
    ) dut64 (
        .clk(clk), .rst(rst),
        .ahbl_hready(hready), .ahbl_hresp(hresp), .ahbl_htrans(htrans),
        .ahbl_hwrite(hwrite), .ahbl_haddr(haddr), .ahbl_hsize(hsize),
        .ahbl_hprot(hprot), .ahbl_hwdata(hwdata), .ahbl_hrdata(hrdata),
        .chan_addr(ca64), .chan_clr(clr64),
        .chan_valid(v64), .chan_data(d64), .chan_mismatch(mm64),
        .chan_checks(ck64), .proto_err(pe64), .err_any(ea64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_V32 = 0, K_D32_0 = 1, K_D32_1 = 2, K_D32_2 = 3, K_MM32 = 4,
                   K_CK32_0 = 5, K_CK32_1 = 6, K_PE32 = 7, K_EA32 = 8,
                   K_V64 = 9, K_D64_0 = 10, K_D64_1 = 11, K_D64_2 = 12,
                   K_MM64 = 13, K_CK64_0 = 14, K_PE64 = 15, K_EA64 = 16;

    int n_tests = 0;
    int n_fail  = 0;

    string       tag_q[$];
    int          kind_q[$];
    logic [63:0] exp_q[$];

    function automatic logic [63:0] obs(input int k);
        case (k)
            K_V32:    return 64'(v32);
            K_D32_0:  return 64'(d32[7:0]);
            K_D32_1:  return 64'(d32[15:8]);
            K_D32_2:  return 64'(d32[23:16]);
            K_MM32:   return 64'(mm32);
            K_CK32_0: return 64'(ck32[1:0]);
            K_CK32_1: return 64'(ck32[3:2]);
            K_PE32:   return 64'(pe32);
            K_EA32:   return 64'(ea32);
            K_V64:    return 64'(v64);
            K_D64_0:  return 64'(d64[7:0]);
            K_D64_1:  return 64'(d64[15:8]);
            K_D64_2:  return 64'(d64[23:16]);
            K_MM64:   return 64'(mm64);
            K_CK64_0: return 64'(ck64[15:0]);
            K_PE64:   return 64'(pe64);
            K_EA64:   return 64'(ea64);
            default:  return 64'hDEAD_DEAD_DEAD_DEAD;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    task automatic expect_val(input string tag, input int kind, input logic [63:0] val);
        tag_q.push_back(tag);
        kind_q.push_back(kind);
        exp_q.push_back(val);
    endtask

    task automatic sb_check();
        while (exp_q.size() > 0) begin
            string       t;
            int          k;
            logic [63:0] e;
            t = tag_q.pop_front();
            k = kind_q.pop_front();
            e = exp_q.pop_front();
            chk(t, obs(k), e);
        end
    endtask

    task automatic bus_idle();
        htrans = HTRANS_IDLE;
        hready = 1'b1;
        hresp  = 1'b0;
    endtask

    task automatic addr_phase(input logic wr, input logic [31:0] a,
                              input logic [2:0] sz, input logic [3:0] pr);
        htrans = HTRANS_NSEQ;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
        hprot  = pr;
        hready = 1'b1;
        hresp  = 1'b0;
        @(posedge clk); #1;
        htrans = HTRANS_IDLE;
    endtask

    task automatic data_ok(input logic [63:0] wd, input logic [63:0] rd);
        hwdata = wd;
        hrdata = rd;
        hready = 1'b1;
        hresp  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [3:0] pr, input logic [63:0] wd, input logic [63:0] rd);
        addr_phase(wr, a, sz, pr);
        data_ok(wd, rd);
        bus_idle();
    endtask

    task automatic idle_cycles(input int n);
        bus_idle();
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst    = 1'b1;
        htrans = HTRANS_IDLE;
        hready = 1'b1;
        hresp  = 1'b0;
        hwrite = 1'b0;
        haddr  = 32'h0;
        hsize  = HSIZE_BYTE;
        hprot  = 4'b1111;
        hwdata = 64'h0;
        hrdata = 64'h0;
        clr32  = 4'b0000;
        clr64  = 4'b0000;
        ca32   = {32'h80, 32'h40, 32'h13, 32'h13};
        ca64   = {32'h100, 32'h28, 32'h2F, 32'h13};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        expect_val("reset_v32", K_V32, 0);
        expect_val("reset_ck32", K_CK32_0, 0);
        expect_val("reset_pe32", K_PE32, 0);
        expect_val("reset_ea32", K_EA32, 0);
        expect_val("reset_v64", K_V64, 0);
        sb_check();
        idle_cycles(2);
        expect_val("idle_pe32", K_PE32, 0);
        expect_val("idle_pe64", K_PE64, 0);
        sb_check();

        // Word write then byte read of the watched byte.
        xfer(1'b1, 32'h10, HSIZE_WORD, 4'b1111, 64'h0000_0000_1122_3344, 64'h0);
        expect_val("wr_v32", K_V32, 4'b0011);
        expect_val("wr_d32_0", K_D32_0, 8'h11);
        expect_val("wr_d32_1", K_D32_1, 8'h11);
        expect_val("wr_v64", K_V64, 4'b0001);
        expect_val("wr_d64_0", K_D64_0, 8'h11);
        sb_check();
        xfer(1'b0, 32'h13, HSIZE_BYTE, 4'b1111, 64'h0, 64'h0000_0000_1100_0000);
        expect_val("rd_ck32_0", K_CK32_0, 1);
        expect_val("rd_ck32_1", K_CK32_1, 1);
        expect_val("rd_mm32", K_MM32, 0);
        expect_val("rd_ck64", K_CK64_0, 1);
        sb_check();

        // Halfword read returning the wrong upper byte.
        xfer(1'b0, 32'h12, HSIZE_HALF, 4'b1111, 64'h0, 64'h0000_0000_5544_0000);
        expect_val("mm_mm32", K_MM32, 4'b0011);
        expect_val("mm_ea32", K_EA32, 1);
        expect_val("mm_ck32", K_CK32_0, 2);
        expect_val("mm_mm64", K_MM64, 4'b0001);
        expect_val("mm_ea64", K_EA64, 1);
        expect_val("mm_pe32", K_PE32, 0);
        sb_check();
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 32'h13, HSIZE_BYTE, 4'b1111, 64'h0, 64'h0000_0000_1100_0000);
        end
        expect_val("sticky_mm32", K_MM32, 4'b0011);
        expect_val("sat_ck32_0", K_CK32_0, 3);
        expect_val("sat_ck32_1", K_CK32_1, 3);
        expect_val("nosat_ck64", K_CK64_0, 6);
        sb_check();

        // Clear keeps the counter but drops valid and mismatch.
        clr32 = 4'b0011;
        @(posedge clk); #1;
        clr32 = 4'b0000;
        expect_val("clr_v32", K_V32, 0);
        expect_val("clr_mm32", K_MM32, 0);
        expect_val("clr_ea32", K_EA32, 0);
        expect_val("clr_ck32", K_CK32_0, 3);
        expect_val("clr_mm64", K_MM64, 4'b0001);
        sb_check();

        // Byte write, then an error-answered write to the same byte.
        xfer(1'b1, 32'h13, HSIZE_BYTE, 4'b1111, 64'h0000_0000_AB00_0000, 64'h0);
        expect_val("bw_v32", K_V32, 4'b0011);
        expect_val("bw_d32_0", K_D32_0, 8'hAB);
        expect_val("bw_d64_0", K_D64_0, 8'hAB);
        sb_check();
        addr_phase(1'b1, 32'h13, HSIZE_BYTE, 4'b1111);
        hwdata = 64'h0000_0000_CD00_0000;
        hresp  = 1'b1;
        hready = 1'b0;
        @(posedge clk); #1;
        hready = 1'b1;
        @(posedge clk); #1;
        bus_idle();
        expect_val("errw_v32", K_V32, 0);
        expect_val("errw_pe32", K_PE32, 0);
        expect_val("errw_v64", K_V64, 0);
        expect_val("errw_pe64", K_PE64, 0);
        sb_check();

        // Cacheability filter on the 64-bit instance.
        xfer(1'b1, 32'h28, HSIZE_DWORD, 4'b0011, 64'hF1E2_D3C4_B5A6_9788, 64'h0);
        expect_val("nc_v64", K_V64, 0);
        sb_check();
        xfer(1'b1, 32'h28, HSIZE_DWORD, 4'b1111, 64'hF1E2_D3C4_B5A6_9788, 64'h0);
        expect_val("c_v64", K_V64, 4'b0110);
        expect_val("c_d64_1", K_D64_1, 8'hF1);
        expect_val("c_d64_2", K_D64_2, 8'h88);
        expect_val("c_v32", K_V32, 0);
        sb_check();
        xfer(1'b1, 32'h28, HSIZE_DWORD, 4'b0011, 64'h1111_1111_1111_1111, 64'h0);
        expect_val("nc2_v64", K_V64, 0);
        expect_val("nc2_d64_1", K_D64_1, 8'hF1);
        sb_check();

        // Clear wins over a same-cycle write.
        xfer(1'b1, 32'h40, HSIZE_BYTE, 4'b1111, 64'h0000_0000_0000_005A, 64'h0);
        expect_val("w40_v32", K_V32, 4'b0100);
        expect_val("w40_d32_2", K_D32_2, 8'h5A);
        sb_check();
        addr_phase(1'b1, 32'h40, HSIZE_BYTE, 4'b1111);
        clr32 = 4'b0100;
        data_ok(64'h0000_0000_0000_0077, 64'h0);
        clr32 = 4'b0000;
        bus_idle();
        expect_val("clrw_v32", K_V32, 0);
        expect_val("clrw_d32_2", K_D32_2, 8'h5A);
        sb_check();

        // IDLE data phase stretched by hready low.
        hready = 1'b0;
        @(posedge clk); #1;
        hready = 1'b1;
        expect_val("idle_wait_pe32", K_PE32, 1);
        expect_val("idle_wait_ea32", K_EA32, 1);
        expect_val("idle_wait_pe64", K_PE64, 1);
        sb_check();

        // Reset in the middle of a transfer clears everything at once.
        addr_phase(1'b0, 32'h13, HSIZE_BYTE, 4'b1111);
        hrdata = 64'h0000_0000_AB00_0000;
        rst = 1'b1;
        #1;
        expect_val("rst_v32", K_V32, 0);
        expect_val("rst_ck32", K_CK32_0, 0);
        expect_val("rst_pe32", K_PE32, 0);
        expect_val("rst_ea32", K_EA32, 0);
        expect_val("rst_mm64", K_MM64, 0);
        expect_val("rst_ck64", K_CK64_0, 0);
        expect_val("rst_pe64", K_PE64, 0);
        sb_check();
        @(posedge clk); #1;
        bus_idle();
        rst = 1'b0;
        idle_cycles(3);
        expect_val("post_rst_pe32", K_PE32, 0);
        expect_val("post_rst_ck64", K_CK64_0, 0);
        sb_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ahbl_mem_contract_monitor.md
Name: ahbl_mem_contract_monitor

Overview:
- Synthesisable, passive AHB-Lite monitor enforcing the memory contract "a byte read returns the last successfully written value", plus basic AHB-Lite response-protocol checks.
- Watches N_CHAN independent byte addresses at once, for any power-of-two bus width.
- Attaches to any AHB-Lite port (cache upstream, bus fabric slave side). The same instance serves simulation benches and formal runs; formal drives chan_addr from unconstrained constants.

Parameters:
- W_ADDR, 32, address width.
- W_DATA, 32, data width; power of two, 32 to 128.
- N_CHAN, 4, number of independently tracked byte addresses.
- W_CNT, 16, width of each saturating per-channel check counter.
- REQ_CACHEABLE, 1, if 1 only transfers with hprot[3:2]==2'b11 update or check channels.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- ahbl_hready, input, 1, bus HREADY.
- ahbl_hresp, input, 1, bus HRESP.
- ahbl_htrans, input, 2, bus HTRANS.
- ahbl_hwrite, input, 1, bus HWRITE.
- ahbl_haddr, input, W_ADDR, bus HADDR.
- ahbl_hsize, input, 3, bus HSIZE.
- ahbl_hprot, input, 4, bus HPROT.
- ahbl_hwdata, input, W_DATA, bus HWDATA.
- ahbl_hrdata, input, W_DATA, bus HRDATA.
- chan_addr, input, N_CHAN*W_ADDR, watched byte address per channel; must be held stable while the channel is valid.
- chan_clr, input, N_CHAN, synchronous clear of the channel's valid flag and mismatch flag.
- chan_valid, output, N_CHAN, channel holds a known written byte.
- chan_data, output, N_CHAN*8, last written byte per channel.
- chan_mismatch, output, N_CHAN, sticky: a read returned data different from chan_data.
- chan_checks, output, N_CHAN*W_CNT, saturating count of successful compared reads.
- proto_err, output, 1, sticky AHB-Lite response-protocol violation.
- err_any, output, 1, OR of chan_mismatch and proto_err.

Behaviour:
- Reset: all outputs and internal registers go to 0.
- Address-phase capture:
  - On each clk edge with ahbl_hready=1, register active=htrans[1], plus write, addr, size, prot.
  - These registers describe the data phase in the following cycles.
- Data-phase completion: a cycle with active && hready.
- Overlap, per channel: addr_dph <= chan_addr < addr_dph + (1<<size_dph), computed at W_ADDR+1 bits so there is no wrap.
- Byte lane: chan_addr % (W_DATA/8).
- Qualified: REQ_CACHEABLE==0, or prot_dph[3:2]==2'b11.
- Write completion, overlap, qualified:
  - hresp=0: chan_data <= hwdata lane, chan_valid <= 1.
  - hresp=1: chan_valid <= 0, because the target state is unknown.
- Write completion, overlap, not qualified: chan_valid <= 0.
- Read completion, overlap, qualified, hresp=0, chan_valid=1:
  - compare hrdata lane with chan_data;
  - mismatch sets chan_mismatch (sticky);
  - chan_checks increments, saturating at all-ones.
- Read completion that has hresp=1, no overlap, or chan_valid=0: no channel effect.
- chan_clr[i] takes priority over a same-cycle write update. The channel ends the cycle invalid with mismatch cleared; chan_checks is not cleared.
- Protocol checks (proto_err set, sticky) when any of these holds:
  - !active && (!hready || hresp);
  - hresp && hready without hresp && !hready on the previous cycle;
  - hresp && !hready on the previous cycle without hresp this cycle;
  - hresp && !hready on two consecutive cycles.
- The first cycle after reset deassertion is exempt from the $past-style checks. Use a registered first-cycle flag.
- Several channels may watch the same address. They update independently and identically.
- Latency: every output is registered and reflects a completion one cycle after the completing edge.

Decomposition:
- Package ahbl_defs:
  - HTRANS encodings IDLE/BUSY/NSEQ/SEQ;
  - HSIZE constants;
  - HPROT bit indices for cacheable and bufferable.
- Sub-module ahbl_mem_contract_chan: one channel, holding the valid, data, mismatch and counter logic. Instantiate it N_CHAN times in a generate loop.
- The top level holds the data-phase tracker and the protocol checker.

Test Plan:
1. W_DATA=32, chan0 addr 0x13. Word write 0x11223344 to 0x10, then byte read of 0x13 returning 0x11 -> chan_valid[0]=1, chan_data=0x11, chan_checks=1, no mismatch.
2. Same write, then halfword read of 0x12 returning 0x5544 -> chan_mismatch[0]=1, err_any=1; the flag stays set after later correct reads.
3. Write to 0x13 answered with a two-phase error (hresp high with hready low, then hready high) -> chan_valid[0]=0, proto_err=0.
4. W_DATA=64, chan1 addr 0x2F, hprot=4'b0011, REQ_CACHEABLE=1, write to 0x28 -> chan_valid[1]=0. Repeat with hprot=4'b1111 -> chan_valid[1]=1 and the lane 7 byte is captured.
5. IDLE data phase with hready=0 -> proto_err=1 one cycle later. Assert rst mid-burst -> all outputs 0 immediately.
6. W_CNT=2, 5 matching reads -> chan_checks saturates at 3. chan_clr in the same cycle as a write -> chan_valid=0.
